// File: rtl/uart_column_scheduler_if.sv
// Matrix-in / transmitter-out bundle for uart_column_scheduler.
// slave = scheduler side, master = producer/transmitter side.
interface uart_column_scheduler_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_btint_a;
  logic [127:0] in_btint_b;
  logic [31:0]  in_overflow;
  logic [127:0] tx_btint_a;
  logic [127:0] tx_btint_b;
  logic [31:0]  tx_overflow;
  logic [31:0]  tx_column;
  logic         tx_reset_active_low;
  logic         busy;
  logic         done;

  modport slave (
    input  in_valid,
    input  in_btint_a,
    input  in_btint_b,
    input  in_overflow,
    output in_ready,
    output tx_btint_a,
    output tx_btint_b,
    output tx_overflow,
    output tx_column,
    output tx_reset_active_low,
    output busy,
    output done
  );

  modport master (
    output in_valid,
    output in_btint_a,
    output in_btint_b,
    output in_overflow,
    input  in_ready,
    input  tx_btint_a,
    input  tx_btint_b,
    input  tx_overflow,
    input  tx_column,
    input  tx_reset_active_low,
    input  busy,
    input  done
  );
endinterface

// File: rtl/uart_column_scheduler.sv
// Snapshots one 4x4 BTINT matrix and steps the UART transmitter through
// columns 0..3 (REPEAT_COUNT times); ports: clock, async low reset, bus.
module uart_column_scheduler #(
  parameter int BIT_CYCLES    = 10000000,
  parameter int FRAME_BITS    = 56,
  parameter int REPEAT_COUNT  = 1,
  parameter int COUNTER_WIDTH = 32
) (
  input  logic uart_column_scheduler_clock,
  input  logic uart_column_scheduler_reset_active_low,
  uart_column_scheduler_if.slave bus
);

  localparam logic [COUNTER_WIDTH-1:0] FRAME_LAST =
    COUNTER_WIDTH'(BIT_CYCLES * FRAME_BITS - 1);
  localparam logic [COUNTER_WIDTH-1:0] RPT_LAST =
    COUNTER_WIDTH'(REPEAT_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_FINISH
  } state_t;

  logic clk;
  logic rst_n;
  assign clk   = uart_column_scheduler_clock;
  assign rst_n = uart_column_scheduler_reset_active_low;

  state_t                   state_q, state_d;
  logic [127:0]             a_q, a_d;
  logic [127:0]             b_q, b_d;
  logic [31:0]              ov_q, ov_d;
  logic [1:0]               col_q, col_d;
  logic [COUNTER_WIDTH-1:0] rpt_q, rpt_d;
  logic [COUNTER_WIDTH-1:0] cyc_q, cyc_d;
  logic                     txrst_q, txrst_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic frame_end;
  logic last_col;
  logic more_rpt;

  assign frame_end = (cyc_q == FRAME_LAST);
  assign last_col  = (col_q == 2'd3);
  assign more_rpt  = (rpt_q < RPT_LAST);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ov_d    = ov_q;
    col_d   = col_q;
    rpt_d   = rpt_q;
    cyc_d   = cyc_q;
    txrst_d = txrst_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        txrst_d = 1'b0;
        if (bus.in_valid) begin
          a_d     = bus.in_btint_a;
          b_d     = bus.in_btint_b;
          ov_d    = bus.in_overflow;
          col_d   = 2'd0;
          rpt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      // Transmitter is still held in reset across this edge,
      // so its first frame starts from a known bit position.
      S_LOAD: begin
        cyc_d   = '0;
        txrst_d = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (frame_end) begin
          cyc_d = '0;
          unique case (1'b1)
            !last_col: begin
              col_d = col_q + 2'd1;
            end
            // Wrap to column 0 without dropping the
            // transmitter reset, so the line never glitches.
            last_col && more_rpt: begin
              col_d = 2'd0;
              rpt_d = rpt_q + 1'b1;
            end
            default: begin
              txrst_d = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = S_FINISH;
            end
          endcase
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ov_q    <= '0;
      col_q   <= '0;
      rpt_q   <= '0;
      cyc_q   <= '0;
      txrst_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ov_q    <= ov_d;
      col_q   <= col_d;
      rpt_q   <= rpt_d;
      cyc_q   <= cyc_d;
      txrst_q <= txrst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.in_ready            = (state_q == S_IDLE);
  assign bus.tx_btint_a          = a_q;
  assign bus.tx_btint_b          = b_q;
  assign bus.tx_overflow         = ov_q;
  assign bus.tx_column           = {30'd0, col_q};
  assign bus.tx_reset_active_low = txrst_q;
  assign bus.busy                = busy_q;
  assign bus.done                = done_q;

endmodule

// File: tb/tb_uart_column_scheduler.sv
// Directed bench for uart_column_scheduler: one instance with
// REPEAT_COUNT=1 and one with REPEAT_COUNT=2, BIT_CYCLES=4.
module tb_uart_column_scheduler;

  localparam int FRAME = 224;

  logic clk = 1'b0;
  logic rst_n;
  logic v1, v2;
  logic [127:0] in_a, in_b;
  logic [31:0]  in_ov;
  bit sel;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  uart_column_scheduler_if if1 ();
  uart_column_scheduler_if if2 ();

  assign if1.in_valid    = v1;
  assign if1.in_btint_a  = in_a;
  assign if1.in_btint_b  = in_b;
  assign if1.in_overflow = in_ov;
  assign if2.in_valid    = v2;
  assign if2.in_btint_a  = in_a;
  assign if2.in_btint_b  = in_b;
  assign if2.in_overflow = in_ov;

  uart_column_scheduler #(
    .BIT_CYCLES(4), .FRAME_BITS(56),
    .REPEAT_COUNT(1), .COUNTER_WIDTH(32)
  ) dut1 (
    .uart_column_scheduler_clock(clk),
    .uart_column_scheduler_reset_active_low(rst_n),
    .bus(if1.slave)
  );

  uart_column_scheduler #(
    .BIT_CYCLES(4), .FRAME_BITS(56),
    .REPEAT_COUNT(2), .COUNTER_WIDTH(32)
  ) dut2 (
    .uart_column_scheduler_clock(clk),
    .uart_column_scheduler_reset_active_low(rst_n),
    .bus(if2.slave)
  );

  logic [127:0] o_a, o_b;
  logic [31:0]  o_ov, o_col;
  logic         o_rst, o_busy, o_done, o_rdy;

  always_comb begin
    o_a    = sel ? if2.tx_btint_a : if1.tx_btint_a;
    o_b    = sel ? if2.tx_btint_b : if1.tx_btint_b;
    o_ov   = sel ? if2.tx_overflow : if1.tx_overflow;
    o_col  = sel ? if2.tx_column : if1.tx_column;
    o_rst  = sel ? if2.tx_reset_active_low
                 : if1.tx_reset_active_low;
    o_busy = sel ? if2.busy : if1.busy;
    o_done = sel ? if2.done : if1.done;
    o_rdy  = sel ? if2.in_ready : if1.in_ready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  // Called in the LOAD cycle (cycle 1 after accept); walks SEND,
  // FINISH and the following IDLE cycle.
  task automatic run(input string tag, input int ncols,
                     input logic [127:0] ea,
                     input logic [127:0] eb,
                     input logic [31:0] eov,
                     input bit churn);
    int bad_col  = 0;
    int bad_rst  = 0;
    int bad_busy = 0;
    int bad_done = 0;
    int bad_snap = 0;
    int last = 1 + ncols * FRAME;
    for (int c = 2; c <= last; c++) begin
      tick();
      if (churn) begin
        in_a  = {$urandom, $urandom, $urandom, $urandom};
        in_b  = {$urandom, $urandom, $urandom, $urandom};
        in_ov = $urandom;
      end
      if (o_col !== 32'(((c - 2) / FRAME) % 4)) bad_col++;
      if (o_rst !== 1'b1) bad_rst++;
      if (o_busy !== 1'b1) bad_busy++;
      if (o_done !== 1'b0) bad_done++;
      if (o_a !== ea || o_b !== eb || o_ov !== eov)
        bad_snap++;
      if (c == 1 + FRAME)
        check({tag, " col_before_edge"}, o_col, 0);
      if (c == 2 + FRAME)
        check({tag, " col_after_edge"}, o_col, 1);
    end
    check({tag, " col_sequence_errs"}, bad_col, 0);
    check({tag, " txrst_glitch_errs"}, bad_rst, 0);
    check({tag, " busy_errs"}, bad_busy, 0);
    check({tag, " early_done_errs"}, bad_done, 0);
    check({tag, " snapshot_errs"}, bad_snap, 0);
    tick();
    check({tag, " finish_done"}, o_done, 1);
    check({tag, " finish_busy"}, o_busy, 0);
    check({tag, " finish_txrst"}, o_rst, 0);
    check({tag, " finish_ready"}, o_rdy, 0);
    tick();
    check({tag, " idle_done_clear"}, o_done, 0);
    check({tag, " idle_ready"}, o_rdy, 1);
  endtask

  logic [127:0] ea, eb;
  logic [31:0]  eov;
  bit seen;

  initial begin
    sel   = 1'b0;
    rst_n = 1'b0;
    v1    = 1'b0;
    v2    = 1'b0;
    in_a  = '0;
    in_b  = '0;
    in_ov = '0;

    // reset values
    repeat (3) tick();
    check("rst_col", o_col, 0);
    check("rst_txrst", o_rst, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_snap_a", o_a, 0);
    check("rst_snap_ov", o_ov, 0);

    // idle with no traffic
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (50) begin
      tick();
      if (o_done) seen = 1'b1;
    end
    check("idle_done_never", seen, 0);
    check("idle_ready", o_rdy, 1);
    check("idle_busy", o_busy, 0);
    check("idle_txrst", o_rst, 0);
    check("idle_col", o_col, 0);

    // single matrix, element (r,c) = r*4+c
    for (int i = 0; i < 16; i++) begin
      in_a[i*8+:8]  = 8'(i);
      in_b[i*8+:8]  = 8'(8'h40 + i);
      in_ov[i*2+:2] = 2'(i);
    end
    ea = in_a; eb = in_b; eov = in_ov;
    v1 = 1'b1;
    check("m1_ready", o_rdy, 1);
    tick();
    v1 = 1'b0;
    check("m1_load_busy", o_busy, 1);
    check("m1_load_ready", o_rdy, 0);
    check("m1_load_txrst", o_rst, 0);
    check("m1_load_a", o_a, ea);
    check("m1_load_b", o_b, eb);
    check("m1_load_ov", o_ov, eov);
    run("m1", 4, ea, eb, eov, 1'b0);

    // valid held high with churning data
    in_a = {4{32'hA5A5_0F0F}};
    in_b = {4{32'h1234_5678}};
    in_ov = 32'hDEAD_BEEF;
    ea = in_a; eb = in_b; eov = in_ov;
    v1 = 1'b1;
    tick();
    check("m2_load_a", o_a, ea);
    run("m2", 4, ea, eb, eov, 1'b1);
    in_a = {4{32'h0102_0304}};
    in_b = {4{32'hFFEE_DDCC}};
    in_ov = 32'h5555_AAAA;
    ea = in_a; eb = in_b; eov = in_ov;
    tick();
    v1 = 1'b0;
    check("m3_accept_busy", o_busy, 1);
    check("m3_accept_a", o_a, ea);
    check("m3_accept_ov", o_ov, eov);

    // async reset mid column 1 (SEND cycle_cnt 300)
    repeat (301) tick();
    check("m3_mid_col", o_col, 1);
    check("m3_mid_txrst", o_rst, 1);
    rst_n = 1'b0;
    #1;
    check("async_txrst", o_rst, 0);
    check("async_busy", o_busy, 0);
    check("async_col", o_col, 0);
    check("async_done", o_done, 0);
    check("async_snap_a", o_a, 0);
    check("async_snap_ov", o_ov, 0);
    tick();
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (o_done) seen = 1'b1;
    end
    check("post_rst_no_done", seen, 0);
    check("post_rst_ready", o_rdy, 1);

    // new matrix after reset sends from column 0
    in_a = {4{32'hCAFE_F00D}};
    in_b = {4{32'h0BAD_C0DE}};
    in_ov = 32'h0F0F_3C3C;
    ea = in_a; eb = in_b; eov = in_ov;
    v1 = 1'b1;
    tick();
    v1 = 1'b0;
    check("m4_load_col", o_col, 0);
    run("m4", 4, ea, eb, eov, 1'b0);

    // REPEAT_COUNT=2 instance
    sel = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_a[i*8+:8]  = 8'(8'hF0 - i);
      in_b[i*8+:8]  = 8'(i * 3);
      in_ov[i*2+:2] = 2'(3 - (i % 4));
    end
    ea = in_a; eb = in_b; eov = in_ov;
    check("r2_ready", o_rdy, 1);
    v2 = 1'b1;
    tick();
    v2 = 1'b0;
    check("r2_load_txrst", o_rst, 0);
    check("r2_load_a", o_a, ea);
    run("r2", 8, ea, eb, eov, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
